// File: rtl/controlador_de_jogo_pkg.sv
// Shared definitions for the battleship attack sequencer.
// Holds the FSM state encoding and the 5x7 board geometry.
// Imported by controlador_de_jogo and its sub-modules.
package controlador_de_jogo_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int NUM_CELULAS = NUM_COLUNAS * NUM_LINHAS;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CONTAGEM = 3'd1,
    JOGANDO  = 3'd2,
    VALIDA   = 3'd3,
    DISPARO  = 3'd4,
    AVALIA   = 3'd5,
    VITORIA  = 3'd6,
    DERROTA  = 3'd7
  } estado_t;

endpackage

// File: rtl/controlador_de_jogo_detector_de_borda.sv
// Rising-edge detector for an already synchronized button level.
// Ports: clock, reset (sync, active-high), nivel (level in), pulso (1-cycle edge out).
// History resets to 1 so a button held through reset never produces an edge.
module detector_de_borda (
  input  logic clock,
  input  logic reset,
  input  logic nivel,
  output logic pulso
);

  logic anterior;

  always_ff @(posedge clock) begin
    if (reset) begin
      anterior <= 1'b1;
    end else begin
      anterior <= nivel;
    end
  end

  assign pulso = nivel & ~anterior;

endmodule

// File: rtl/controlador_de_jogo.sv
// Attack sequencer for battleship on the 5x7 LED matrix: counts ships, validates shots,
// pulses confirmarAtaque with stable coordinates, tracks hits/shots, declares victory/defeat.
// Ports: clock/reset, btnIniciar/btnConfirmar levels, coord inputs, mapa0..4 in; registered
// attack controls, counters and end flags out.
module controlador_de_jogo #(
  parameter int MAX_TENTATIVAS = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnIniciar,
  input  logic       btnConfirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic       enableAtaque,
  output logic       confirmarAtaque,
  output logic [2:0] colunaAtaque,
  output logic [2:0] linhaAtaque,
  output logic [5:0] acertos,
  output logic [5:0] tentativas,
  output logic [5:0] totalAlvos,
  output logic       ultimoAcerto,
  output logic       jogadaInvalida,
  output logic       vitoria,
  output logic       derrota
);

  import controlador_de_jogo_pkg::*;

  function automatic logic [5:0] popcount(input logic [6:0] v);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 7; i++) s = s + 6'(v[i]);
    return s;
  endfunction

  estado_t                estado;
  logic [2:0]             idx;
  logic [NUM_CELULAS-1:0] atacado;

  logic       pulso_iniciar;
  logic       pulso_confirmar;
  logic [6:0] coluna_contagem;
  logic [6:0] coluna_tiro;
  logic [5:0] total_prox;
  logic [5:0] posicao;
  logic       fora_do_tabuleiro;
  logic       ja_atacado;
  logic       tiro_valido;

  detector_de_borda u_borda_iniciar (
    .clock (clock),
    .reset (reset),
    .nivel (btnIniciar),
    .pulso (pulso_iniciar)
  );

  detector_de_borda u_borda_confirmar (
    .clock (clock),
    .reset (reset),
    .nivel (btnConfirmar),
    .pulso (pulso_confirmar)
  );

  always_comb begin
    coluna_contagem = 7'd0;
    case (idx)
      3'd0: coluna_contagem = mapa0;
      3'd1: coluna_contagem = mapa1;
      3'd2: coluna_contagem = mapa2;
      3'd3: coluna_contagem = mapa3;
      3'd4: coluna_contagem = mapa4;
      default: coluna_contagem = 7'd0;
    endcase
  end

  always_comb begin
    coluna_tiro = 7'd0;
    case (colunaAtaque)
      3'd0: coluna_tiro = mapa0;
      3'd1: coluna_tiro = mapa1;
      3'd2: coluna_tiro = mapa2;
      3'd3: coluna_tiro = mapa3;
      3'd4: coluna_tiro = mapa4;
      default: coluna_tiro = 7'd0;
    endcase
  end

  assign total_prox = totalAlvos + popcount(coluna_contagem);

  // Linear cell index; only meaningful once the coordinates are known in range.
  assign posicao           = 6'(colunaAtaque) * 6'd7 + 6'(linhaAtaque);
  assign fora_do_tabuleiro = (colunaAtaque > 3'(NUM_COLUNAS - 1)) ||
                             (linhaAtaque  > 3'(NUM_LINHAS - 1));
  assign ja_atacado        = fora_do_tabuleiro ? 1'b0 : atacado[posicao];
  assign tiro_valido       = !fora_do_tabuleiro && !ja_atacado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      idx             <= '0;
      atacado         <= '0;
      enableAtaque    <= 1'b0;
      confirmarAtaque <= 1'b0;
      colunaAtaque    <= '0;
      linhaAtaque     <= '0;
      acertos         <= '0;
      tentativas      <= '0;
      totalAlvos      <= '0;
      ultimoAcerto    <= 1'b0;
      jogadaInvalida  <= 1'b0;
      vitoria         <= 1'b0;
      derrota         <= 1'b0;
    end else begin
      confirmarAtaque <= 1'b0;
      jogadaInvalida  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (pulso_iniciar) begin
            acertos      <= '0;
            tentativas   <= '0;
            totalAlvos   <= '0;
            ultimoAcerto <= 1'b0;
            atacado      <= '0;
            idx          <= '0;
            enableAtaque <= 1'b1;
            estado       <= CONTAGEM;
          end
        end
        CONTAGEM: begin
          totalAlvos <= total_prox;
          idx        <= idx + 3'd1;
          if (idx == 3'(NUM_COLUNAS - 1)) begin
            // An empty map is an immediate win.
            if (total_prox == 6'd0) begin
              vitoria <= 1'b1;
              estado  <= VITORIA;
            end else begin
              estado  <= JOGANDO;
            end
          end
        end
        JOGANDO: begin
          if (pulso_confirmar) begin
            colunaAtaque <= coordColuna;
            linhaAtaque  <= coordLinha;
            estado       <= VALIDA;
          end
        end
        VALIDA: begin
          // Pulse is registered here so it is high exactly during DISPARO.
          if (tiro_valido) begin
            confirmarAtaque <= 1'b1;
            estado          <= DISPARO;
          end else begin
            jogadaInvalida  <= 1'b1;
            estado          <= JOGANDO;
          end
        end
        DISPARO: begin
          atacado[posicao] <= 1'b1;
          tentativas       <= tentativas + 6'd1;
          if (coluna_tiro[linhaAtaque]) begin
            acertos      <= acertos + 6'd1;
            ultimoAcerto <= 1'b1;
          end else begin
            ultimoAcerto <= 1'b0;
          end
          estado <= AVALIA;
        end
        AVALIA: begin
          if (acertos == totalAlvos) begin
            vitoria <= 1'b1;
            estado  <= VITORIA;
          end else if (tentativas == 6'(MAX_TENTATIVAS)) begin
            derrota <= 1'b1;
            estado  <= DERROTA;
          end else begin
            estado  <= JOGANDO;
          end
        end
        VITORIA, DERROTA: begin
          if (pulso_iniciar) begin
            vitoria      <= 1'b0;
            derrota      <= 1'b0;
            enableAtaque <= 1'b0;
            estado       <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_de_jogo.sv
// Directed self-checking bench for controlador_de_jogo.
// Map: 8 ship cells (0,0),(0,4),(0,5),(0,6),(1,5),(4,4),(4,5),(4,6).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_controlador_de_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       btnIniciar;
  logic       btnConfirmar;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic       enableAtaque;
  logic       confirmarAtaque;
  logic [2:0] colunaAtaque;
  logic [2:0] linhaAtaque;
  logic [5:0] acertos;
  logic [5:0] tentativas;
  logic [5:0] totalAlvos;
  logic       ultimoAcerto;
  logic       jogadaInvalida;
  logic       vitoria;
  logic       derrota;

  int testes = 0;
  int falhas = 0;

  int         n_conf;
  int         n_inv;
  int         ciclo_conf;
  logic [2:0] col_conf;
  logic [2:0] lin_conf;

  int alvo_c [8] = '{0, 0, 0, 0, 1, 4, 4, 4};
  int alvo_l [8] = '{0, 4, 5, 6, 5, 4, 5, 6};

  controlador_de_jogo #(.MAX_TENTATIVAS(15)) dut (
    .clock           (clock),
    .reset           (reset),
    .btnIniciar      (btnIniciar),
    .btnConfirmar    (btnConfirmar),
    .coordColuna     (coordColuna),
    .coordLinha      (coordLinha),
    .mapa0           (mapa0),
    .mapa1           (mapa1),
    .mapa2           (mapa2),
    .mapa3           (mapa3),
    .mapa4           (mapa4),
    .enableAtaque    (enableAtaque),
    .confirmarAtaque (confirmarAtaque),
    .colunaAtaque    (colunaAtaque),
    .linhaAtaque     (linhaAtaque),
    .acertos         (acertos),
    .tentativas      (tentativas),
    .totalAlvos      (totalAlvos),
    .ultimoAcerto    (ultimoAcerto),
    .jogadaInvalida  (jogadaInvalida),
    .vitoria         (vitoria),
    .derrota         (derrota)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    testes++;
    if (obtido !== esperado) begin
      falhas++;
      $display("FAIL %s: got %0d, required %0d", tag, obtido, esperado);
    end
  endtask

  function automatic logic [29:0] saidas();
    return {enableAtaque, confirmarAtaque, colunaAtaque, linhaAtaque, acertos,
            tentativas, totalAlvos, ultimoAcerto, jogadaInvalida, vitoria, derrota};
  endfunction

  // One start press; returns one falling edge after the press.
  task automatic pressiona_iniciar();
    btnIniciar = 1'b1;
    @(negedge clock);
    btnIniciar = 1'b0;
  endtask

  // Start press plus the five counting cycles; returns with the FSM in JOGANDO.
  task automatic inicia_jogo();
    pressiona_iniciar();
    repeat (5) @(negedge clock);
  endtask

  // One fire press; observes five cycles, recording confirm/invalid pulses.
  task automatic dispara(input int c, input int l);
    n_conf     = 0;
    n_inv      = 0;
    ciclo_conf = -1;
    col_conf   = '0;
    lin_conf   = '0;
    coordColuna  = 3'(c);
    coordLinha   = 3'(l);
    btnConfirmar = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) btnConfirmar = 1'b0;
      if (confirmarAtaque) begin
        n_conf++;
        ciclo_conf = k;
        col_conf   = colunaAtaque;
        lin_conf   = linhaAtaque;
      end
      if (jogadaInvalida) n_inv++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    btnIniciar   = 1'b0;
    btnConfirmar = 1'b0;
    coordColuna  = '0;
    coordLinha   = '0;
    mapa0 = 7'b1110001;
    mapa1 = 7'b0100000;
    mapa2 = 7'b0000000;
    mapa3 = 7'b0000000;
    mapa4 = 7'b1110000;

    // Reset with start held: must not fire when reset drops.
    btnIniciar = 1'b1;
    repeat (3) @(negedge clock);
    verifica("reset_outputs", 32'(saidas()), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    verifica("held_start_ignored", 32'(enableAtaque), 32'd0);
    btnIniciar = 1'b0;
    @(negedge clock);

    // 1. Counting phase.
    pressiona_iniciar();
    verifica("count_enable", 32'(enableAtaque), 32'd1);
    verifica("count_total_start", 32'(totalAlvos), 32'd0);
    repeat (4) @(negedge clock);
    verifica("count_total_4cyc", 32'(totalAlvos), 32'd5);
    @(negedge clock);
    verifica("count_total_final", 32'(totalAlvos), 32'd8);

    // 2. First hit.
    dispara(0, 0);
    verifica("hit_conf_count", 32'(n_conf), 32'd1);
    verifica("hit_conf_cycle", 32'(ciclo_conf), 32'd2);
    verifica("hit_conf_col", 32'(col_conf), 32'd0);
    verifica("hit_conf_lin", 32'(lin_conf), 32'd0);
    verifica("hit_acertos", 32'(acertos), 32'd1);
    verifica("hit_tentativas", 32'(tentativas), 32'd1);
    verifica("hit_ultimo", 32'(ultimoAcerto), 32'd1);

    // 3. Repeated and out-of-range shots.
    dispara(0, 0);
    verifica("rep_inv", 32'(n_inv), 32'd1);
    verifica("rep_conf", 32'(n_conf), 32'd0);
    dispara(5, 2);
    verifica("col5_inv", 32'(n_inv), 32'd1);
    verifica("col5_conf", 32'(n_conf), 32'd0);
    dispara(1, 7);
    verifica("lin7_inv", 32'(n_inv), 32'd1);
    verifica("lin7_conf", 32'(n_conf), 32'd0);
    verifica("inv_acertos", 32'(acertos), 32'd1);
    verifica("inv_tentativas", 32'(tentativas), 32'd1);

    // 4. Miss.
    dispara(2, 3);
    verifica("miss_conf_col", 32'(col_conf), 32'd2);
    verifica("miss_conf_lin", 32'(lin_conf), 32'd3);
    verifica("miss_ultimo", 32'(ultimoAcerto), 32'd0);
    verifica("miss_tentativas", 32'(tentativas), 32'd2);
    verifica("miss_acertos", 32'(acertos), 32'd1);

    // 5a. Eight straight hits from a fresh game.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    inicia_jogo();
    for (int i = 0; i < 8; i++) begin
      dispara(alvo_c[i], alvo_l[i]);
      if (i == 6) verifica("win8_not_yet", 32'(vitoria), 32'd0);
    end
    verifica("win8_vitoria", 32'(vitoria), 32'd1);
    verifica("win8_acertos", 32'(acertos), 32'd8);
    verifica("win8_tentativas", 32'(tentativas), 32'd8);
    dispara(2, 0);
    verifica("win8_hold_tent", 32'(tentativas), 32'd8);

    // Restart from victory.
    pressiona_iniciar();
    verifica("restart_enable", 32'(enableAtaque), 32'd0);
    verifica("restart_vitoria", 32'(vitoria), 32'd0);
    @(negedge clock);

    // 5b. Seven misses then eight hits: last hit is shot 15.
    inicia_jogo();
    for (int l = 0; l < 7; l++) dispara(2, l);
    for (int i = 0; i < 7; i++) dispara(alvo_c[i], alvo_l[i]);
    verifica("win15_pre_derrota", 32'(derrota), 32'd0);
    verifica("win15_pre_tent", 32'(tentativas), 32'd14);
    dispara(alvo_c[7], alvo_l[7]);
    verifica("win15_vitoria", 32'(vitoria), 32'd1);
    verifica("win15_derrota", 32'(derrota), 32'd0);
    verifica("win15_tentativas", 32'(tentativas), 32'd15);

    pressiona_iniciar();
    @(negedge clock);

    // 6. Fifteen misses -> defeat.
    inicia_jogo();
    for (int c = 2; c <= 3; c++)
      for (int l = 0; l < 7; l++) dispara(c, l);
    verifica("lose_pre_derrota", 32'(derrota), 32'd0);
    dispara(1, 0);
    verifica("lose_derrota", 32'(derrota), 32'd1);
    verifica("lose_vitoria", 32'(vitoria), 32'd0);
    verifica("lose_acertos", 32'(acertos), 32'd0);
    verifica("lose_tentativas", 32'(tentativas), 32'd15);
    pressiona_iniciar();
    verifica("lose_restart_enable", 32'(enableAtaque), 32'd0);
    verifica("lose_restart_derrota", 32'(derrota), 32'd0);
    @(negedge clock);

    // Reset asserted while in DISPARO.
    inicia_jogo();
    coordColuna  = 3'd4;
    coordLinha   = 3'd6;
    btnConfirmar = 1'b1;
    @(negedge clock);
    btnConfirmar = 1'b0;
    @(negedge clock);
    verifica("rst_disparo_conf", 32'(confirmarAtaque), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    verifica("rst_disparo_outputs", 32'(saidas()), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    verifica("rst_disparo_idle", 32'(saidas()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
